// File: rtl/mem_wb_stage_if.sv
// MEM -> WB stage bundle: MEM-side controls and operands in, WB results out.
// master is the MEM/hazard side, slave is the WB register stage.
interface mem_wb_stage_if #(
  parameter int OPERAND_WIDTH = 32,
  parameter int RF_ADDR_WIDTH = 5
);
  logic                     stall;
  logic                     flush;
  logic                     in_valid;
  logic [OPERAND_WIDTH-1:0] alu_result;
  logic [31:0]              mem_data;
  logic [OPERAND_WIDTH-1:0] pc_plus4;
  logic [RF_ADDR_WIDTH-1:0] rd_addr;
  logic                     ctrl_reg_write;
  logic [1:0]               ctrl_wb_sel;
  logic [2:0]               ctrl_load_size;

  logic                     wb_valid;
  logic                     wb_reg_write;
  logic [RF_ADDR_WIDTH-1:0] wb_rd_addr;
  logic [OPERAND_WIDTH-1:0] wb_data;
  logic                     wb_load_fault;
  logic [31:0]              retire_count;

  modport master (
    output stall, flush, in_valid,
    output alu_result, mem_data, pc_plus4,
    output rd_addr, ctrl_reg_write,
    output ctrl_wb_sel, ctrl_load_size,
    input  wb_valid, wb_reg_write,
    input  wb_rd_addr, wb_data,
    input  wb_load_fault, retire_count
  );

  modport slave (
    input  stall, flush, in_valid,
    input  alu_result, mem_data, pc_plus4,
    input  rd_addr, ctrl_reg_write,
    input  ctrl_wb_sel, ctrl_load_size,
    output wb_valid, wb_reg_write,
    output wb_rd_addr, wb_data,
    output wb_load_fault, retire_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extraction, alignment fault check,
// write-back mux and retired-instruction counter.
module mem_wb_stage #(
  parameter int OPERAND_WIDTH = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst,
  mem_wb_stage_if.slave  bus
);

  logic [1:0]  offset;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic        ld_fault;

  logic is_lb, is_lh, is_lw;
  logic is_lbu, is_lhu;
  logic sel_alu, sel_load;
  logic sel_link, sel_rsvd;

  logic [OPERAND_WIDTH-1:0] nxt_data;
  logic                     nxt_fault;
  logic                     nxt_rw;

  logic                     valid_q;
  logic                     rw_q;
  logic [RF_ADDR_WIDTH-1:0] rd_q;
  logic [OPERAND_WIDTH-1:0] data_q;
  logic                     fault_q;
  logic [31:0]              retire_q;

  assign offset = bus.alu_result[1:0];

  assign is_lb  = bus.ctrl_load_size == 3'b000;
  assign is_lh  = bus.ctrl_load_size == 3'b001;
  assign is_lw  = bus.ctrl_load_size == 3'b010;
  assign is_lbu = bus.ctrl_load_size == 3'b100;
  assign is_lhu = bus.ctrl_load_size == 3'b101;

  assign sel_alu  = bus.ctrl_wb_sel == 2'b00;
  assign sel_load = bus.ctrl_wb_sel == 2'b01;
  assign sel_link = bus.ctrl_wb_sel == 2'b10;
  assign sel_rsvd = bus.ctrl_wb_sel == 2'b11;

  always_comb begin
    ld_byte = bus.mem_data[7:0];
    unique case (offset)
      2'd0: ld_byte = bus.mem_data[7:0];
      2'd1: ld_byte = bus.mem_data[15:8];
      2'd2: ld_byte = bus.mem_data[23:16];
      2'd3: ld_byte = bus.mem_data[31:24];
      default: ld_byte = bus.mem_data[7:0];
    endcase
    ld_half = offset[1] ? bus.mem_data[31:16]
                        : bus.mem_data[15:0];
  end

  // Undefined funct3 encodings land in default and fault.
  always_comb begin
    ld_value = '0;
    ld_fault = 1'b0;
    unique case (1'b1)
      is_lb:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      is_lbu: ld_value = {24'd0, ld_byte};
      is_lh: begin
        ld_value = {{16{ld_half[15]}}, ld_half};
        ld_fault = offset[0];
      end
      is_lhu: begin
        ld_value = {16'd0, ld_half};
        ld_fault = offset[0];
      end
      is_lw: begin
        ld_value = bus.mem_data;
        ld_fault = offset != 2'd0;
      end
      default: ld_fault = 1'b1;
    endcase
  end

  always_comb begin
    nxt_data  = '0;
    nxt_fault = 1'b0;
    unique case (1'b1)
      sel_alu:  nxt_data = bus.alu_result;
      sel_load: begin
        nxt_fault = ld_fault;
        nxt_data  = ld_fault ? '0 : ld_value;
      end
      sel_link: nxt_data = bus.pc_plus4;
      sel_rsvd: nxt_data = '0;
      default:  nxt_data = '0;
    endcase
  end

  assign nxt_rw = bus.in_valid
                & bus.ctrl_reg_write
                & (bus.rd_addr != '0)
                & ~nxt_fault;

  // Flush leaves rd/data untouched; only the qualifiers matter then.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      rw_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      fault_q  <= 1'b0;
      retire_q <= '0;
    end else if (bus.flush) begin
      valid_q  <= 1'b0;
      rw_q     <= 1'b0;
      fault_q  <= 1'b0;
    end else if (!bus.stall) begin
      valid_q  <= bus.in_valid;
      rw_q     <= nxt_rw;
      rd_q     <= bus.rd_addr;
      data_q   <= nxt_data;
      fault_q  <= nxt_fault;
      retire_q <= retire_q + {31'd0, bus.in_valid};
    end
  end

  assign bus.wb_valid      = valid_q;
  assign bus.wb_reg_write  = rw_q;
  assign bus.wb_rd_addr    = rd_q;
  assign bus.wb_data       = data_q;
  assign bus.wb_load_fault = fault_q;
  assign bus.retire_count  = retire_q;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 32, datapath width (only 32 supported).
REQ-002 SHALL have parameter RF_ADDR_WIDTH, default 5, register-file index width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port stall  in  1  hold all WB registers.
REQ-007 SHALL have port flush  in  1  kill instruction entering WB.
REQ-008 SHALL have port in_valid  in  1  MEM-stage slot holds a real instruction.
REQ-009 SHALL have port alu_result  in  OPERAND_WIDTH  ALU result / memory address.
REQ-010 SHALL have port mem_data  in  32  raw aligned word read from data memory.
REQ-011 SHALL have port pc_plus4  in  OPERAND_WIDTH  link value for JAL/JALR.
REQ-012 SHALL have port rd_addr  in  RF_ADDR_WIDTH  destination register.
REQ-013 SHALL have port ctrl_reg_write  in  1  instruction writes rd.
REQ-014 SHALL have port ctrl_wb_sel  in  2  00 ALU, 01 load, 10 pc_plus4, 11 reserved.
REQ-015 SHALL have port ctrl_load_size  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-016 SHALL have port wb_valid  out  1  WB slot holds a real instruction.
REQ-017 SHALL have port wb_reg_write  out  1  register-file write enable.
REQ-018 SHALL have port wb_rd_addr  out  RF_ADDR_WIDTH  register-file write index.
REQ-019 SHALL have port wb_data  out  OPERAND_WIDTH  register-file write data (also forwarding source).
REQ-020 SHALL have port wb_load_fault  out  1  WB instruction is a misaligned or illegal load.
REQ-021 SHALL have port retire_count  out  32  count of instructions that entered WB.

Function
REQ-022 SHALL register all outputs; latency MEM inputs -> WB outputs is exactly one cycle.
REQ-023 SHALL give update priority rst > flush > stall > normal capture.
REQ-024 SHALL, on flush (stall irrelevant), load wb_valid=0, wb_reg_write=0, wb_load_fault=0; wb_data/wb_rd_addr don't-care.
REQ-025 SHALL, on stall without flush, hold every output including retire_count.
REQ-026 SHALL, on normal capture, load wb_valid=in_valid and compute wb_data from ctrl_wb_sel.
REQ-027 SHALL select wb_data: ALU -> alu_result; link -> pc_plus4; reserved -> 0; load -> extracted value.
REQ-028 SHALL extract with offset = alu_result[1:0]: byte = mem_data[8*offset+7 : 8*offset]; half = mem_data[16*offset[1]+15 : 16*offset[1]].
REQ-029 SHALL sign-extend for LB/LH, zero-extend for LBU/LHU, and pass the whole word for LW.
REQ-030 SHALL flag a fault for a load when: LH/LHU with offset[0]=1, LW with offset!=0, or ctrl_load_size in {011,110,111}.
REQ-031 SHALL, on a faulting load, set wb_load_fault=1, wb_data=0, wb_reg_write=0, wb_valid=in_valid.
REQ-032 SHALL set wb_reg_write = in_valid & ctrl_reg_write & (rd_addr!=0) & no fault.
REQ-033 SHALL ignore ctrl_load_size and report no fault when ctrl_wb_sel!=01.
REQ-034 SHALL increment retire_count by 1 on each normal capture with in_valid=1, wrapping 0xFFFFFFFF -> 0.
REQ-035 SHALL not count flushed, stalled or in_valid=0 cycles; faulting loads are counted.

Reset
REQ-036 SHALL, on rst high at a rising edge, set wb_valid=0, wb_reg_write=0, wb_rd_addr=0, wb_data=0, wb_load_fault=0, retire_count=0.
REQ-037 SHALL let rst override flush/stall in the same cycle and discard any instruction being captured.

Verification
REQ-038 SHALL cover LB at offset 3, mem_data=0x80FF1234 -> next cycle wb_data=0xFFFFFF80, wb_reg_write=1.
REQ-039 SHALL cover LHU at offset 2, mem_data=0x80FF1234 -> wb_data=0x000080FF; LH at offset 1 -> wb_load_fault=1, wb_reg_write=0, wb_data=0.
REQ-040 SHALL cover ALU op rd=0, alu_result=0x55 -> wb_data=0x55, wb_valid=1, wb_reg_write=0, retire_count+1.
REQ-041 SHALL cover stall for 3 cycles with new inputs -> outputs and retire_count frozen; flush+stall together -> wb_valid=0, count unchanged.
REQ-042 SHALL cover retire_count preloaded to 0xFFFFFFFF via 2^32-1 captures (or forced) then one valid capture -> 0.
REQ-043 SHALL cover rst asserted during a valid load capture -> all outputs 0 next cycle, no count increment.
